piso_tx_sched: RTL and testbench
================================

Name: piso_tx_sched

Overview:
- Controller and round-robin arbiter that shares one WIDTH-bit parallel-in/serial-out shift datapath between two requesters.
- Accepts parallel words over valid/ready handshakes, loads the shifter, then sequences WIDTH shift cycles MSB-first.
- Inserts a programmable inter-frame gap and emits framing strobes for the downstream serial consumer.

Parameters:
- WIDTH, 4, bits per frame (>=2).
- GAP, 1, idle cycles forced after each frame (0 allowed).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits new grants; does not stop a frame in progress.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- serial_out  output  1  current serial bit, MSB first; 0 when not shifting.
- bit_valid  output  1  serial_out carries a frame bit.
- frame_start  output  1  high during first bit of a frame.
- frame_done  output  1  high during last bit of a frame.
- grant_id  output  1  requester owning the current/last frame.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, SHIFT, GAP.
- Reset (async, immediate): state=IDLE, shift reg=0, bit counter=0, gap counter=0, last_grant=1, grant_id=0. All outputs 0.
- IDLE:
  - readyN = enable && reqN_valid && arbiter selects N. Combinational; at most one ready high.
  - Arbiter: one valid wins outright. Both valid: grant the requester != last_grant. After reset req0 wins first.
  - Handshake edge (valid && ready): load reqN_data into shifter, grant_id<=N, last_grant<=N, bit counter<=WIDTH-1, state->SHIFT.
  - No handshake: stay IDLE.
- Requester rule: valid, once high, stays high with data stable until ready. The block does not check this.
- SHIFT:
  - bit_valid=1; serial_out=shifter MSB.
  - Each edge: shift left, zero-fill LSB, decrement counter.
  - frame_start = (counter==WIDTH-1). frame_done = (counter==0).
  - On the edge where counter==0: state->GAP if GAP>0 (gap counter<=GAP-1), else IDLE.
  - Ready outputs stay 0.
- GAP: all outputs except busy/grant_id are 0. Decrement gap counter; at 0 go to IDLE.
- Latency:
  - Handshake at edge E: first bit on cycle after E; last bit WIDTH cycles after E.
  - Earliest next handshake is the first IDLE cycle.
  - Max throughput is one frame per WIDTH+GAP+1 cycles.
- enable low: no grants. Deasserted mid-frame: current frame and gap complete, then block idles.
- Reset mid-frame: frame aborted, no frame_done. After release the arbiter restarts with req0 priority.
- frame_start and frame_done are both high on the same cycle only if WIDTH==1, which is disallowed.
- Counter widths: $clog2(WIDTH) and $clog2(GAP+1), min 1 bit. No wrap: counters reload on entry only.

Decomposition:
- Package piso_sched_pkg: state enum (IDLE/SHIFT/GAP), REQ0/REQ1 grant constants.
- Sub-module piso_shifter: WIDTH-bit register with async reset, load (parallel), shift-left zero-fill, msb output.
- FSM, counters and arbiter stay in piso_tx_sched.

Test Plan:
- Reset: rst high mid-sim with random inputs -> every output 0 immediately; after release, both valid -> req0_ready high first.
- Single frame (WIDTH=4, GAP=1): req0_valid, data 4'b1011, handshake at edge E -> serial_out 1,0,1,1 on cycles E+1..E+4. frame_start at E+1, frame_done at E+4, grant_id=0. GAP cycle E+5, req0_ready possible at E+6.
- Contention: both valid continuously, req0=4'hA, req1=4'h5 -> grants 0,1,0,1. Stream 1010,0101,1010,0101, each frame separated by 1 gap + 1 idle cycle.
- Enable gating: enable=0 with req1_valid=1 for 10 cycles -> no ready, busy=0. Drop enable during bit 2 of a frame -> frame finishes all 4 bits plus gap, then no further grant.
- Reset mid-frame: assert rst during bit 2 of 4'b1111 -> serial_out and bit_valid drop same cycle, no frame_done. After release, a new 4'b0110 shifts cleanly.
- GAP=0 build: req0 continuously valid with 4'b1001 -> frames separated by exactly one IDLE cycle; frame_done then ready high on consecutive cycles.

Source files
------------

// File: rtl/piso_sched_pkg.sv
// Shared types and constants for the two-requester PISO transmit scheduler.
package piso_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, shift-left zero-fill register; presents its MSB as the serial bit.
module piso_shifter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load_i) begin
         sreg_d = data_i;
      end else if (shift_i) begin
         sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one PISO shifter between two requesters,
// with framing strobes and a programmable inter-frame gap.
module piso_tx_sched
   import piso_sched_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             serial_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_done,
   output logic             grant_id,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic            last_grant_q, last_grant_d;
   logic            grant_id_q, grant_id_d;
   logic            sel0, sel1;
   logic            load, shift, msb;

   // Contention goes to whichever requester did not win last time.
   assign sel1 = req1_valid && (!req0_valid || (last_grant_q == REQ0));
   assign sel0 = req0_valid && !sel1;

   piso_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .shift_i (shift),
      .data_i  (req1_ready ? req1_data : req0_data),
      .msb_o   (msb)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      load         = 1'b0;
      shift        = 1'b0;
      serial_out   = 1'b0;
      bit_valid    = 1'b0;
      frame_start  = 1'b0;
      frame_done   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Ready is masked while reset is held so no output leaks during reset.
            if (enable && !rst) begin
               req0_ready = sel0;
               req1_ready = sel1;
            end
            if (req0_ready || req1_ready) begin
               load         = 1'b1;
               grant_id_d   = req1_ready ? REQ1 : REQ0;
               last_grant_d = req1_ready ? REQ1 : REQ0;
               bit_cnt_d    = CW'(WIDTH - 1);
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bit_valid   = 1'b1;
            serial_out  = msb;
            shift       = 1'b1;
            frame_start = (bit_cnt_q == CW'(WIDTH - 1));
            frame_done  = (bit_cnt_q == '0);
            if (frame_done) begin
               if (GAP > 0) begin
                  gap_cnt_d = GW'(GAP - 1);
                  state_d   = S_GAP;
               end else begin
                  state_d   = S_IDLE;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - CW'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         gap_cnt_q    <= '0;
         last_grant_q <= REQ1;
         grant_id_q   <= REQ0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: a GAP=1 instance for most scenarios
// and a GAP=0 instance for the back-to-back throughput case.
module tb_piso_tx_sched;

   localparam int W = 4;

   typedef struct packed {
      logic b;
      logic fs;
      logic fd;
      logic gid;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         r0v = 1'b0, r1v = 1'b0;
   logic [W-1:0] r0d = '0, r1d = '0;
   logic         req0_ready, req1_ready, serial_out, bit_valid;
   logic         frame_start, frame_done, grant_id, busy;

   logic         g_v = 1'b0;
   logic [W-1:0] g_d = '0;
   logic         g_ready, g_r1_ready, g_serial, g_bv, g_fs, g_fd, g_gid, g_busy;

   int   checks = 0;
   int   failures = 0;
   exp_t sbq[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   piso_tx_sched #(.WIDTH(W), .GAP(1)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .req0_valid(r0v), .req0_data(r0d), .req0_ready(req0_ready),
      .req1_valid(r1v), .req1_data(r1d), .req1_ready(req1_ready),
      .serial_out(serial_out), .bit_valid(bit_valid),
      .frame_start(frame_start), .frame_done(frame_done),
      .grant_id(grant_id), .busy(busy)
   );

   piso_tx_sched #(.WIDTH(W), .GAP(0)) dut0 (
      .clk(clk), .rst(rst), .enable(1'b1),
      .req0_valid(g_v), .req0_data(g_d), .req0_ready(g_ready),
      .req1_valid(1'b0), .req1_data('0), .req1_ready(g_r1_ready),
      .serial_out(g_serial), .bit_valid(g_bv),
      .frame_start(g_fs), .frame_done(g_fd),
      .grant_id(g_gid), .busy(g_busy)
   );

   // Every emitted bit of the main instance is checked against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (bit_valid) begin
            checks++;
            if (sbq.size() == 0) begin
               failures++;
               $display("FAIL monitor_unexpected_bit serial_out=%0b scoreboard empty", serial_out);
            end else begin
               mon_e = sbq.pop_front();
               if ({serial_out, frame_start, frame_done, grant_id} !== mon_e) begin
                  failures++;
                  $display("FAIL monitor_bit got {so,fs,fd,gid}=%b expected %b",
                           {serial_out, frame_start, frame_done, grant_id}, mon_e);
               end
            end
         end else begin
            checks++;
            if ({serial_out, frame_start, frame_done} !== 3'b000) begin
               failures++;
               $display("FAIL monitor_idle_strobes {so,fs,fd}=%b expected 000",
                        {serial_out, frame_start, frame_done});
            end
         end
      end
   end

   task automatic push_frame(input logic [W-1:0] d, input logic gid);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.b   = d[i];
         e.fs  = (i == W - 1);
         e.fd  = (i == 0);
         e.gid = gid;
         sbq.push_back(e);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         enable = 1'b1;
         r0v = 1'($urandom);
         r1v = 1'b1;
         r0d = W'($urandom);
         r1d = W'($urandom);
         #1;
         checks++;
         if ({req0_ready, req1_ready, serial_out, bit_valid, frame_start, frame_done, grant_id, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got %b expected 00000000",
                     {req0_ready, req1_ready, serial_out, bit_valid, frame_start, frame_done, grant_id, busy});
         end
      end
      @(negedge clk);
      rst = 1'b0;
      r0v = 1'b1; r1v = 1'b1; r0d = 4'hC; r1d = 4'h3;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL reset_priority {r0rdy,r1rdy}=%b expected 10", {req0_ready, req1_ready});
      end
      push_frame(4'hC, 1'b0);
      @(posedge clk);
      #1;
      r0v = 1'b0; r1v = 1'b0;
      for (int t = 0; t < 30 && (sbq.size() != 0 || busy); t++) @(negedge clk);
      checks++;
      if (sbq.size() != 0 || busy) begin
         failures++;
         $display("FAIL reset_drain left=%0d busy=%0b expected 0 0", sbq.size(), busy);
      end
   endtask

   task automatic test_single_frame();
      @(negedge clk);
      enable = 1'b1; r1v = 1'b0; r0v = 1'b1; r0d = 4'b1011;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_ready got %b expected 1", req0_ready);
      end
      push_frame(4'b1011, 1'b0);
      @(posedge clk);
      @(negedge clk);
      r0v = 1'b0;
      checks++;
      if ({frame_start, grant_id} !== 2'b10) begin
         failures++;
         $display("FAIL single_first_bit {fs,gid}=%b expected 10", {frame_start, grant_id});
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({frame_done, frame_start} !== 2'b10) begin
         failures++;
         $display("FAIL single_last_bit {fd,fs}=%b expected 10", {frame_done, frame_start});
      end
      @(negedge clk);
      r0v = 1'b1;
      #1;
      checks++;
      if ({bit_valid, busy, req0_ready} !== 3'b010) begin
         failures++;
         $display("FAIL single_gap {bv,busy,rdy}=%b expected 010", {bit_valid, busy, req0_ready});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({req0_ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL single_next_ready {rdy,busy}=%b expected 10", {req0_ready, busy});
      end
      r0v = 1'b0;
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL single_drained left=%0d expected 0", sbq.size());
      end
   endtask

   task automatic test_contention();
      int ng = 0;
      int last_cyc = 0;
      logic gid;
      apply_reset();
      enable = 1'b1; r0d = 4'hA; r1d = 4'h5; r0v = 1'b1; r1v = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         #1;
         if (req0_ready || req1_ready) begin
            gid = req1_ready;
            checks++;
            if (gid !== ((ng % 2) == 1)) begin
               failures++;
               $display("FAIL contention_grant_%0d got %0b expected %0b", ng, gid, (ng % 2) == 1);
            end
            if (ng > 0) begin
               checks++;
               if (cyc - last_cyc != W + 2) begin
                  failures++;
                  $display("FAIL contention_spacing_%0d got %0d expected %0d", ng, cyc - last_cyc, W + 2);
               end
            end
            last_cyc = cyc;
            push_frame(gid ? r1d : r0d, gid);
            ng++;
         end
         if (ng == 4) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      r0v = 1'b0; r1v = 1'b0;
      checks++;
      if (ng != 4) begin
         failures++;
         $display("FAIL contention_count got %0d expected 4", ng);
      end
      for (int t = 0; t < 30 && (sbq.size() != 0 || busy); t++) @(negedge clk);
      checks++;
      if (sbq.size() != 0 || busy) begin
         failures++;
         $display("FAIL contention_drain left=%0d busy=%0b expected 0 0", sbq.size(), busy);
      end
   endtask

   task automatic test_enable_gating();
      @(negedge clk);
      enable = 1'b0; r0v = 1'b0; r1v = 1'b1; r1d = 4'b1100;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++;
         if ({req1_ready, busy} !== 2'b00) begin
            failures++;
            $display("FAIL enable_low_idle cycle %0d {rdy,busy}=%b expected 00", i, {req1_ready, busy});
         end
         @(negedge clk);
      end
      enable = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++;
         $display("FAIL enable_resume_ready got %b expected 1", req1_ready);
      end
      push_frame(4'b1100, 1'b1);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({req1_ready, busy} !== {1'b0, (i < 3)}) begin
            failures++;
            $display("FAIL enable_drop cycle %0d {rdy,busy}=%b expected %b", i, {req1_ready, busy}, {1'b0, (i < 3)});
         end
      end
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL enable_frame_complete left=%0d expected 0", sbq.size());
      end
      r1v = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      enable = 1'b1; r1v = 1'b0; r0v = 1'b1; r0d = 4'b1111;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("FAIL midframe_ready got %b expected 1", req0_ready);
      end
      push_frame(4'b1111, 1'b0);
      @(posedge clk);
      @(negedge clk);
      r0v = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({serial_out, bit_valid, frame_start, frame_done, busy} !== 5'b00000) begin
         failures++;
         $display("FAIL midframe_abort {so,bv,fs,fd,busy}=%b expected 00000",
                  {serial_out, bit_valid, frame_start, frame_done, busy});
      end
      sbq.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midframe_no_done got %b expected 0", frame_done);
         end
      end
      rst = 1'b0;
      r0v = 1'b1; r1v = 1'b1; r0d = 4'b0110; r1d = 4'b1001;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("FAIL midframe_restart_priority {r0rdy,r1rdy}=%b expected 10", {req0_ready, req1_ready});
      end
      push_frame(4'b0110, 1'b0);
      @(posedge clk);
      #1;
      r0v = 1'b0; r1v = 1'b0;
      for (int t = 0; t < 30 && (sbq.size() != 0 || busy); t++) @(negedge clk);
      checks++;
      if (sbq.size() != 0 || busy) begin
         failures++;
         $display("FAIL midframe_recover left=%0d busy=%0b expected 0 0", sbq.size(), busy);
      end
   endtask

   task automatic test_gap0_back_to_back();
      exp_t gq[$];
      exp_t e;
      int   ng = 0;
      int   last_hs = 0;
      int   last_done = -10;
      logic drop = 1'b0;
      @(negedge clk);
      g_v = 1'b1; g_d = 4'b1001;
      for (int cyc = 0; cyc < 40 && (ng < 3 || gq.size() != 0); cyc++) begin
         #1;
         if (g_bv) begin
            checks++;
            if (gq.size() == 0) begin
               failures++;
               $display("FAIL gap0_unexpected_bit so=%b queue empty", g_serial);
            end else begin
               e = gq.pop_front();
               if ({g_serial, g_fs, g_fd, g_gid} !== e) begin
                  failures++;
                  $display("FAIL gap0_bit got %b expected %b", {g_serial, g_fs, g_fd, g_gid}, e);
               end
            end
         end
         if (g_fd) last_done = cyc;
         if (g_ready) begin
            if (ng > 0) begin
               checks++;
               if (cyc - last_hs != W + 1) begin
                  failures++;
                  $display("FAIL gap0_period got %0d expected %0d", cyc - last_hs, W + 1);
               end
               checks++;
               if (cyc != last_done + 1) begin
                  failures++;
                  $display("FAIL gap0_done_then_ready ready@%0d done@%0d expected consecutive", cyc, last_done);
               end
            end
            last_hs = cyc;
            for (int i = W - 1; i >= 0; i--) begin
               e.b = g_d[i]; e.fs = (i == W - 1); e.fd = (i == 0); e.gid = 1'b0;
               gq.push_back(e);
            end
            ng++;
            if (ng == 3) drop = 1'b1;
         end
         @(negedge clk);
         if (drop) g_v = 1'b0;
      end
      checks++;
      if (ng != 3 || gq.size() != 0) begin
         failures++;
         $display("FAIL gap0_complete frames=%0d left=%0d expected 3 0", ng, gq.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_contention();
      test_enable_gating();
      test_reset_mid_frame();
      test_gap0_back_to_back();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
